// File: rtl/accel_mag_pkg.sv
// Shared types and width helpers for the accelerometer magnitude datapath.
package accel_mag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SQRT,
    OUT
  } state_e;

  // One squaring per axis through the shared multiplier.
  localparam int ACC_CYCLES = 3;

  function automatic int sum_w(input int data_w);
    return 2 * data_w + 2;
  endfunction

  function automatic int mag_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/int_sqrt_seq.sv
// Restoring integer square root, one root bit per cycle (MSB first), IN_W/2 cycles from start to done.
// start-cycle performs the first iteration straight from radicand; root is valid only while done is high.
module int_sqrt_seq #(
  parameter int IN_W = 34
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IN_W-1:0]     radicand,
  output logic [IN_W/2-1:0]   root,
  output logic                done
);

  localparam int HALF  = IN_W / 2;
  localparam int REM_W = HALF + 2;
  localparam int CNT_W = $clog2(HALF + 1);

  logic [IN_W-1:0]  rad_q, rad_d, rad_src;
  logic [REM_W-1:0] rem_q, rem_d, rem_src;
  logic [HALF-1:0]  root_q, root_d, root_src, root_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [REM_W+1:0] rem_sh;
  logic [REM_W+1:0] trial;
  logic [REM_W-1:0] rem_new;
  logic             ge;
  logic             active;
  logic             last;

  always_comb begin
    rad_src  = start ? radicand : rad_q;
    rem_src  = start ? '0 : rem_q;
    root_src = start ? '0 : root_q;

    // Bring down the next radicand bit pair and try root*4+1.
    rem_sh   = {rem_src, rad_src[IN_W-1 -: 2]};
    trial    = (REM_W + 2)'({root_src, 2'b01});
    ge       = (rem_sh >= trial);
    rem_new  = ge ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
    root_new = {root_src[HALF-2:0], ge};

    active   = start | busy_q;
    last     = start ? (HALF == 1) : (cnt_q == CNT_W'(HALF - 1));

    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (active) begin
      rad_d  = {rad_src[IN_W-3:0], 2'b00};
      rem_d  = rem_new;
      root_d = root_new;
      cnt_d  = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
      busy_d = ~last;
    end
  end

  assign done = active & last;
  assign root = root_new;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/accel_magnitude_unit.sv
// floor(sqrt(x^2+y^2+z^2)) of one sample; 3+MAG_W cycles from input handshake to out_valid.
// Single outstanding sample: in_ready low until the result is consumed; outputs hold under backpressure.
module accel_magnitude_unit
  import accel_mag_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SIGNED_IN = 1,
  parameter int SUM_W     = sum_w(DATA_W),
  parameter int MAG_W     = mag_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] accel_x,
  input  logic [DATA_W-1:0] accel_y,
  input  logic [DATA_W-1:0] accel_z,
  input  logic [MAG_W-1:0]  thr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAG_W-1:0]  magnitude,
  output logic [SUM_W-1:0]  sum_sq,
  output logic              above_thr
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ax_q, ax_d, ay_q, ay_d, az_q, az_d;
  logic [MAG_W-1:0]    thr_q, thr_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [1:0]          acc_cnt_q, acc_cnt_d;
  logic                start_q, start_d;
  logic [MAG_W-1:0]    mag_q, mag_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                above_q, above_d;

  logic [DATA_W-1:0]   mul_a;
  logic [2*DATA_W-1:0] prod;
  logic [MAG_W-1:0]    sq_root;
  logic                sq_done;

  // Most-negative input maps to 2^(DATA_W-1), which still fits unsigned.
  function automatic logic [DATA_W-1:0] abs_axis(input logic [DATA_W-1:0] v);
    if (SIGNED_IN != 0 && v[DATA_W-1]) return (~v) + DATA_W'(1);
    return v;
  endfunction

  always_comb begin
    case (acc_cnt_q)
      2'd0:    mul_a = ax_q;
      2'd1:    mul_a = ay_q;
      default: mul_a = az_q;
    endcase
    prod = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_a};
  end

  always_comb begin
    state_d   = state_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    az_d      = az_q;
    thr_d     = thr_q;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    start_d   = 1'b0;
    mag_d     = mag_q;
    sum_d     = sum_q;
    above_d   = above_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ax_d      = abs_axis(accel_x);
          ay_d      = abs_axis(accel_y);
          az_d      = abs_axis(accel_z);
          thr_d     = thr;
          acc_d     = '0;
          acc_cnt_d = '0;
          state_d   = ACC;
        end
      end
      ACC: begin
        acc_d     = acc_q + SUM_W'(prod);
        acc_cnt_d = acc_cnt_q + 2'd1;
        if (acc_cnt_q == 2'(ACC_CYCLES - 1)) begin
          state_d = SQRT;
          start_d = 1'b1;
        end
      end
      SQRT: begin
        if (sq_done) begin
          mag_d   = sq_root;
          sum_d   = acc_q;
          above_d = (sq_root >= thr_q);
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ax_q      <= '0;
      ay_q      <= '0;
      az_q      <= '0;
      thr_q     <= '0;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      start_q   <= 1'b0;
      mag_q     <= '0;
      sum_q     <= '0;
      above_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      az_q      <= az_d;
      thr_q     <= thr_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      start_q   <= start_d;
      mag_q     <= mag_d;
      sum_q     <= sum_d;
      above_q   <= above_d;
    end
  end

  int_sqrt_seq #(
    .IN_W (SUM_W)
  ) u_sqrt (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_q),
    .radicand (acc_q),
    .root     (sq_root),
    .done     (sq_done)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign magnitude = mag_q;
  assign sum_sq    = sum_q;
  assign above_thr = above_q;

endmodule
